// File: rtl/gray_arb_pkg.sv
// Shared types and defaults for the frame-granular grayscale arbiter.
// Holds the FSM state enum, default geometry and a counter-width helper.
package gray_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } arb_state_t;

  localparam int DATA_W_DEF = 24;
  localparam int IMG_W_DEF  = 640;
  localparam int IMG_H_DEF  = 480;

  // Width of a counter spanning 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gray_frame_geom_counter.sv
// Pixel/line counters for the granted stream.
// Ports: aclk/aresetn, clr (hold at origin), hs/tlast/tuser (beat info),
// eof (comb, last beat of frame), err_line_len/err_sof_mid (1-cycle pulses).
module gray_frame_geom_counter
  import gray_arb_pkg::*;
#(
  parameter int IMAGE_WIDTH  = IMG_W_DEF,
  parameter int IMAGE_HEIGHT = IMG_H_DEF
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic clr,
  input  logic hs,
  input  logic tlast,
  input  logic tuser,
  output logic eof,
  output logic err_line_len,
  output logic err_sof_mid
);

  localparam int XW = cnt_w(IMAGE_WIDTH);
  localparam int YW = cnt_w(IMAGE_HEIGHT);
  localparam logic [XW-1:0] X_MAX = XW'(IMAGE_WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(IMAGE_HEIGHT - 1);

  logic [XW-1:0] x_cnt;
  logic [XW-1:0] x_base;
  logic [XW-1:0] x_nxt;
  logic [YW-1:0] y_cnt;
  logic [YW-1:0] y_base;
  logic [YW-1:0] y_nxt;
  logic          len_bad;
  logic          sof_bad;
  logic          y_end;

  // A tuser beat always counts as pixel (0,0), even mid-frame.
  always_comb begin
    x_base  = tuser ? '0 : x_cnt;
    y_base  = tuser ? '0 : y_cnt;
    sof_bad = tuser && ((x_cnt != '0) || (y_cnt != '0));
    y_end   = (y_base == Y_MAX);
    x_nxt   = x_cnt;
    y_nxt   = y_cnt;
    len_bad = 1'b0;
    if (hs) begin
      if (tlast) begin
        len_bad = (x_base != X_MAX);
        x_nxt   = '0;
        y_nxt   = y_end ? '0 : y_base + YW'(1);
      end else begin
        len_bad = (x_base == X_MAX);
        x_nxt   = len_bad ? x_base : x_base + XW'(1);
        y_nxt   = y_base;
      end
    end
    eof = hs && tlast && y_end;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn || clr) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      x_cnt <= x_nxt;
      y_cnt <= y_nxt;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      err_line_len <= 1'b0;
      err_sof_mid  <= 1'b0;
    end else begin
      err_line_len <= hs && len_bad;
      err_sof_mid  <= hs && sof_bad;
    end
  end

endmodule

// File: rtl/gray_frame_arbiter.sv
// Frame-granular 2:1 AXIS arbiter feeding one grayscale core.
// Ports: s0/s1 slave streams, m master stream, grant_id, busy, pulses.
module gray_frame_arbiter
  import gray_arb_pkg::*;
#(
  parameter int IMAGE_WIDTH  = IMG_W_DEF,
  parameter int IMAGE_HEIGHT = IMG_H_DEF,
  parameter int DATA_W       = DATA_W_DEF
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              s0_axis_tvalid,
  output logic              s0_axis_tready,
  input  logic [DATA_W-1:0] s0_axis_tdata,
  input  logic              s0_axis_tlast,
  input  logic              s0_axis_tuser,
  input  logic              s1_axis_tvalid,
  output logic              s1_axis_tready,
  input  logic [DATA_W-1:0] s1_axis_tdata,
  input  logic              s1_axis_tlast,
  input  logic              s1_axis_tuser,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  output logic              grant_id,
  output logic              busy,
  output logic              frame_done,
  output logic              err_line_len,
  output logic              err_sof_mid
);

  arb_state_t state;
  arb_state_t state_nxt;
  logic       sel;
  logic       sel_nxt;
  logic       last_grant;
  logic       lg_nxt;
  logic       req0;
  logic       req1;
  logic       grant;
  logic       hs;
  logic       eof;

  assign req0     = s0_axis_tvalid && s0_axis_tuser;
  assign req1     = s1_axis_tvalid && s1_axis_tuser;
  assign grant    = (req0 && req1) ? !last_grant : req1;
  assign hs       = m_axis_tvalid && m_axis_tready;
  assign busy     = (state == FRAME);
  assign grant_id = sel;

  // Datapath: zero-latency mux in FRAME, discard non-SOF beats in IDLE.
  always_comb begin
    m_axis_tvalid  = 1'b0;
    m_axis_tdata   = '0;
    m_axis_tlast   = 1'b0;
    m_axis_tuser   = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    unique case (state)
      IDLE: begin
        s0_axis_tready = s0_axis_tvalid && !s0_axis_tuser;
        s1_axis_tready = s1_axis_tvalid && !s1_axis_tuser;
      end
      FRAME: begin
        if (sel) begin
          m_axis_tvalid  = s1_axis_tvalid;
          m_axis_tdata   = s1_axis_tdata;
          m_axis_tlast   = s1_axis_tlast;
          m_axis_tuser   = s1_axis_tuser;
          s1_axis_tready = m_axis_tready;
        end else begin
          m_axis_tvalid  = s0_axis_tvalid;
          m_axis_tdata   = s0_axis_tdata;
          m_axis_tlast   = s0_axis_tlast;
          m_axis_tuser   = s0_axis_tuser;
          s0_axis_tready = m_axis_tready;
        end
      end
      default: ;
    endcase
    // Nothing is accepted while reset is held.
    if (!aresetn) begin
      s0_axis_tready = 1'b0;
      s1_axis_tready = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    lg_nxt    = last_grant;
    unique case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_nxt = FRAME;
          sel_nxt   = grant;
          lg_nxt    = grant;
        end
      end
      FRAME: begin
        if (eof) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state      <= IDLE;
      sel        <= 1'b0;
      last_grant <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      last_grant <= lg_nxt;
      frame_done <= (state == FRAME) && eof;
    end
  end

  gray_frame_geom_counter #(
    .IMAGE_WIDTH (IMAGE_WIDTH),
    .IMAGE_HEIGHT(IMAGE_HEIGHT)
  ) u_geom (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .clr         (state == IDLE),
    .hs          (hs),
    .tlast       (m_axis_tlast),
    .tuser       (m_axis_tuser),
    .eof         (eof),
    .err_line_len(err_line_len),
    .err_sof_mid (err_sof_mid)
  );

endmodule

// File: tb/tb_gray_frame_arbiter.sv
// Directed bench for gray_frame_arbiter on a 4x3 frame geometry.
// Drives both sources and the sink, checks every forwarded beat.
module tb_gray_frame_arbiter;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int DW = 24;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          s0_axis_tvalid = 1'b0;
  logic          s0_axis_tready;
  logic [DW-1:0] s0_axis_tdata = '0;
  logic          s0_axis_tlast = 1'b0;
  logic          s0_axis_tuser = 1'b0;
  logic          s1_axis_tvalid = 1'b0;
  logic          s1_axis_tready;
  logic [DW-1:0] s1_axis_tdata = '0;
  logic          s1_axis_tlast = 1'b0;
  logic          s1_axis_tuser = 1'b0;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic          m_axis_tuser;
  logic          grant_id;
  logic          busy;
  logic          frame_done;
  logic          err_line_len;
  logic          err_sof_mid;

  int tests = 0;
  int fails = 0;
  bit rnd = 1'b0;

  always #5 aclk = ~aclk;

  gray_frame_arbiter #(
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .DATA_W      (DW)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s0_axis_tvalid(s0_axis_tvalid),
    .s0_axis_tready(s0_axis_tready),
    .s0_axis_tdata (s0_axis_tdata),
    .s0_axis_tlast (s0_axis_tlast),
    .s0_axis_tuser (s0_axis_tuser),
    .s1_axis_tvalid(s1_axis_tvalid),
    .s1_axis_tready(s1_axis_tready),
    .s1_axis_tdata (s1_axis_tdata),
    .s1_axis_tlast (s1_axis_tlast),
    .s1_axis_tuser (s1_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .grant_id      (grant_id),
    .busy          (busy),
    .frame_done    (frame_done),
    .err_line_len  (err_line_len),
    .err_sof_mid   (err_sof_mid)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive(input bit s, input bit v,
                       input logic [DW-1:0] d,
                       input bit l, input bit u);
    if (s) begin
      s1_axis_tvalid = v;
      s1_axis_tdata  = d;
      s1_axis_tlast  = l;
      s1_axis_tuser  = u;
    end else begin
      s0_axis_tvalid = v;
      s0_axis_tdata  = d;
      s0_axis_tlast  = l;
      s0_axis_tuser  = u;
    end
  endtask

  function automatic bit rdy(input bit s);
    return s ? s1_axis_tready : s0_axis_tready;
  endfunction

  // One beat from source s; fwd=1 means it must appear on m_axis.
  // el/es/ed: expected err_line_len/err_sof_mid/frame_done afterwards.
  task automatic beat(input bit s, input logic [DW-1:0] d,
                      input bit l, input bit u, input bit fwd,
                      input bit el, input bit es, input bit ed);
    bit hs;
    hs = 1'b0;
    drive(s, 1'b1, d, l, u);
    for (int n = 0; n < 64 && !hs; n++) begin
      if (rnd) m_axis_tready = 1'($urandom_range(0, 1));
      #1;
      if (rdy(s)) begin
        hs = 1'b1;
        if (fwd) begin
          chk("m_tvalid", 32'(m_axis_tvalid), 32'd1);
          chk("m_tdata", 32'(m_axis_tdata), 32'(d));
          chk("m_tlast", 32'(m_axis_tlast), 32'(l));
          chk("m_tuser", 32'(m_axis_tuser), 32'(u));
          chk("grant_id", 32'(grant_id), 32'(s));
          chk("other_rdy", 32'(rdy(!s)), 32'd0);
        end else begin
          chk("discard_mvalid", 32'(m_axis_tvalid), 32'd0);
        end
      end
      step();
    end
    chk("hs_done", 32'(hs), 32'd1);
    drive(s, 1'b0, '0, 1'b0, 1'b0);
    chk("err_line_len", 32'(err_line_len), 32'(el));
    chk("err_sof_mid", 32'(err_sof_mid), 32'(es));
    chk("frame_done", 32'(frame_done), 32'(ed));
  endtask

  task automatic send_frame(input bit s, input logic [DW-1:0] b);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        beat(s, b + DW'(y * W + x), x == W - 1,
             (x == 0) && (y == 0), 1'b1, 1'b0, 1'b0,
             (x == W - 1) && (y == H - 1));
  endtask

  initial begin
    // Reset state
    repeat (3) step();
    chk("rst_mvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_s0rdy", 32'(s0_axis_tready), 32'd0);
    chk("rst_s1rdy", 32'(s1_axis_tready), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    aresetn = 1'b1;
    step();
    chk("idle_busy", 32'(busy), 32'd0);

    // First tie after reset: s0 wins, s1 stalled for whole frame
    drive(1'b1, 1'b1, 24'hB10000, 1'b0, 1'b1);
    send_frame(1'b0, 24'hA00000);
    chk("n1_busy", 32'(busy), 32'd0);
    chk("n1_mvalid", 32'(m_axis_tvalid), 32'd0);
    chk("n1_s1rdy", 32'(s1_axis_tready), 32'd0);
    step();
    chk("n2_busy", 32'(busy), 32'd1);
    chk("n2_grant", 32'(grant_id), 32'd1);
    chk("n2_mvalid", 32'(m_axis_tvalid), 32'd1);
    chk("n2_mdata", 32'(m_axis_tdata), 32'hB10000);
    send_frame(1'b1, 24'hB10000);

    // Third tie goes back to s0; random sink backpressure
    drive(1'b1, 1'b1, 24'hB20000, 1'b0, 1'b1);
    rnd = 1'b1;
    send_frame(1'b0, 24'hA30000);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
    rnd = 1'b0;
    m_axis_tready = 1'b1;
    step();
    chk("rnd_after_busy", 32'(busy), 32'd0);
    chk("rnd_after_mvalid", 32'(m_axis_tvalid), 32'd0);

    // s1 non-SOF beats in IDLE are swallowed
    for (int i = 0; i < 3; i++)
      beat(1'b1, 24'h111 + DW'(i), 1'b0, 1'b0, 1'b0,
           1'b0, 1'b0, 1'b0);

    // Short line, then SOF inside the frame restarts it
    beat(1'b1, 24'hC00000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    beat(1'b1, 24'hC00001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    beat(1'b1, 24'hC00002, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    beat(1'b1, 24'hC00003, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    beat(1'b1, 24'hC00010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i < W * H; i++)
      beat(1'b1, 24'hC00010 + DW'(i), (i % W) == W - 1,
           1'b0, 1'b1, 1'b0, 1'b0, i == W * H - 1);

    // Long line on s0: no tlast at pixel 3 or 4, x holds at 3
    for (int i = 0; i < 5; i++)
      beat(1'b0, 24'hD00000 + DW'(i), 1'b0, i == 0, 1'b1,
           i >= W - 1, 1'b0, 1'b0);
    beat(1'b0, 24'hD00005, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = W; i < W * H; i++)
      beat(1'b0, 24'hD00010 + DW'(i), (i % W) == W - 1,
           1'b0, 1'b1, 1'b0, 1'b0, i == W * H - 1);

    // Reset in the middle of an s1 frame
    beat(1'b1, 24'hE00000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    beat(1'b1, 24'hE00001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 24'hE00002, 1'b0, 1'b0);
    aresetn = 1'b0;
    step();
    chk("mr_mvalid", 32'(m_axis_tvalid), 32'd0);
    chk("mr_mdata", 32'(m_axis_tdata), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_grant", 32'(grant_id), 32'd0);
    chk("mr_s1rdy", 32'(s1_axis_tready), 32'd0);
    chk("mr_done", 32'(frame_done), 32'd0);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
    aresetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mr_post_done", 32'(frame_done), 32'd0);
      chk("mr_post_busy", 32'(busy), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
